// File: rtl/param_dpram_clr_if.sv
// Bus bundle for param_dpram_clr: system state, write/read request fields and
// the registered read response with its status flags.
interface param_dpram_clr_if #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 3
);
    // Handshake: a read is requested by holding re_a high across one rising
    // edge; the response appears on q_a with q_valid high for exactly the
    // following cycle. Writes take effect on the edge where we_a is high.
    // Requests made while init_busy is high or the state is not IDLE/ACTIVE
    // are dropped and answered by a one-cycle access_err pulse instead.
    logic [3:0]        state;
    logic [WIDTH-1:0]  data_a;
    logic [ADDR_W-1:0] addr_wa;
    logic [ADDR_W-1:0] addr_ra;
    logic              we_a;
    logic              re_a;
    logic [WIDTH-1:0]  q_a;
    logic              q_valid;
    logic              init_busy;
    logic              access_err;
    logic              dbg_ready;

    modport master (
        output state, data_a, addr_wa, addr_ra, we_a, re_a,
        input  q_a, q_valid, init_busy, access_err, dbg_ready
    );

    modport slave (
        input  state, data_a, addr_wa, addr_ra, we_a, re_a,
        output q_a, q_valid, init_busy, access_err, dbg_ready
    );
endinterface

// File: rtl/param_dpram_clr.sv
// Simple dual-port RAM (one write, one read, single clock) that zeroes itself
// after every reset, gated by the one-hot system state.
module param_dpram_clr #(
    parameter int WIDTH  = 12,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    param_dpram_clr_if.slave  bus
);
    typedef enum logic {
        FSM_CLEAR = 1'b0,
        FSM_READY = 1'b1
    } fsm_e;

    localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];

    fsm_e              fsm_q;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [WIDTH-1:0]  q_q;
    logic              q_valid_q;
    logic              err_q;
    logic              busy_q;

    logic              port_en;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic [WIDTH-1:0]  rd_data_d;
    logic              err_d;

    always_comb begin
        port_en     = (bus.state == 4'b0100) || (bus.state == 4'b1000);
        wr_in_range = {1'b0, bus.addr_wa} < DEPTH_W;
        rd_in_range = {1'b0, bus.addr_ra} < DEPTH_W;
        wr_ok       = (fsm_q == FSM_READY) && port_en && bus.we_a && wr_in_range;
        rd_ok       = (fsm_q == FSM_READY) && port_en && bus.re_a;

        // The clear sweep owns the write port until the FSM reaches READY.
        mem_we = (fsm_q == FSM_CLEAR) || wr_ok;
        mem_wa = (fsm_q == FSM_CLEAR) ? clr_ptr_q : bus.addr_wa;
        mem_wd = (fsm_q == FSM_CLEAR) ? '0 : bus.data_a;

        if (!rd_in_range) begin
            rd_data_d = '0;
        end else if ((BYPASS != 0) && wr_ok && (bus.addr_wa == bus.addr_ra)) begin
            rd_data_d = bus.data_a;
        end else begin
            rd_data_d = mem[bus.addr_ra];
        end

        if ((fsm_q == FSM_CLEAR) || !port_en) begin
            err_d = bus.we_a || bus.re_a;
        end else begin
            err_d = (bus.we_a && !wr_in_range) || (bus.re_a && !rd_in_range);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= FSM_CLEAR;
            clr_ptr_q <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            err_q <= err_d;
            case (fsm_q)
                FSM_CLEAR: begin
                    q_valid_q <= 1'b0;
                    if (clr_ptr_q == LAST) begin
                        fsm_q     <= FSM_READY;
                        busy_q    <= 1'b0;
                        clr_ptr_q <= '0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
                    end
                end
                FSM_READY: begin
                    q_valid_q <= rd_ok;
                    if (rd_ok) begin
                        q_q <= rd_data_d;
                    end
                end
                default: begin
                    fsm_q <= FSM_CLEAR;
                end
            endcase
        end
    end

    assign bus.q_a        = q_q;
    assign bus.q_valid    = q_valid_q;
    assign bus.init_busy  = busy_q;
    assign bus.access_err = err_q;
    assign bus.dbg_ready  = (fsm_q == FSM_READY);
endmodule
